// File: rtl/rvc_fetch_aligner_pkg.sv
// Shared definitions for the RVC fetch aligner: FSM states, opcode constants
// and the compressed-parcel test.
package rvc_fetch_aligner_pkg;

    localparam int ILEN = 32;
    localparam logic [1:0] RVC_OPC_FULL = 2'b11;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HAVE  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    // A 16-bit parcel starts a compressed instruction unless its low opcode bits are 11.
    function automatic logic is_rvc(input logic [15:0] half);
        return half[1:0] != RVC_OPC_FULL;
    endfunction

endpackage

// File: rtl/rvc_parcel_select.sv
// Chooses the next instruction parcel from the fetched word, the carried-over
// low half of a straddling instruction, and the halfword offset of the PC.
module rvc_parcel_select
    import rvc_fetch_aligner_pkg::*;
(
    input  logic [ILEN-1:0] wbuf,
    input  logic [15:0]     hbuf,
    input  logic            hbuf_valid,
    input  logic            off,
    output logic [ILEN-1:0] parcel,
    output logic            is_compressed,
    output logic            has_parcel,
    output logic            needs_next_word
);

    always_comb begin
        parcel          = '0;
        is_compressed   = 1'b0;
        has_parcel      = 1'b0;
        needs_next_word = 1'b0;
        if (hbuf_valid) begin
            // Straddling instruction: saved low half plus low half of the new word.
            parcel     = {wbuf[15:0], hbuf};
            has_parcel = 1'b1;
        end else if (!off) begin
            has_parcel = 1'b1;
            if (is_rvc(wbuf[15:0])) begin
                parcel        = {16'b0, wbuf[15:0]};
                is_compressed = 1'b1;
            end else begin
                parcel = wbuf;
            end
        end else if (is_rvc(wbuf[31:16])) begin
            parcel        = {16'b0, wbuf[31:16]};
            is_compressed = 1'b1;
            has_parcel    = 1'b1;
        end else begin
            needs_next_word = 1'b1;
        end
    end

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Fetch stage feeding the RVC decompressor: reads 32-bit words one at a time and
// hands out 16/32-bit parcels, including 32-bit instructions that cross a word.
module rvc_fetch_aligner
    import rvc_fetch_aligner_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    output logic        inst_is_compressed
);

    fetch_state_e    state;
    logic [31:0]     pc;
    logic [ILEN-1:0] wbuf;
    logic [15:0]     hbuf;
    logic            hbuf_valid;

    fetch_state_e    pre_state;
    logic [31:0]     pre_pc;
    logic [ILEN-1:0] pre_wbuf;
    logic            pre_hbuf_valid;
    logic            outstanding;

    fetch_state_e    nxt_state;
    logic [15:0]     nxt_hbuf;
    logic            nxt_hbuf_valid;
    logic [31:0]     fetch_pc;

    logic [ILEN-1:0] sel_parcel;
    logic            sel_compressed;
    logic            sel_has_parcel;
    logic            sel_needs_next;

    // First pass: apply this cycle's memory, handshake and redirect events.
    always_comb begin
        pre_state      = state;
        pre_pc         = pc;
        pre_wbuf       = wbuf;
        pre_hbuf_valid = hbuf_valid;
        outstanding    = 1'b0;
        case (state)
            ST_REQ: begin
                if (imem_req) begin
                    pre_state   = ST_WAIT;
                    outstanding = 1'b1;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    pre_wbuf  = imem_rdata;
                    pre_state = ST_HAVE;
                end else begin
                    outstanding = 1'b1;
                end
            end
            ST_HAVE: begin
                if (inst_valid && inst_ready) begin
                    if (hbuf_valid) begin
                        pre_pc         = pc + 32'd4;
                        pre_hbuf_valid = 1'b0;
                    end else if (inst_is_compressed) begin
                        pre_pc = pc + 32'd2;
                        if (pc[1]) pre_state = ST_REQ;
                    end else begin
                        pre_pc    = pc + 32'd4;
                        pre_state = ST_REQ;
                    end
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid) pre_state = ST_REQ;
                else             outstanding = 1'b1;
            end
            default: pre_state = ST_REQ;
        endcase
        // A response arriving with the redirect is simply dropped, so it no longer counts as outstanding.
        if (redirect_valid) begin
            pre_pc         = redirect_pc & ~32'd1;
            pre_hbuf_valid = 1'b0;
            pre_state      = outstanding ? ST_DRAIN : ST_REQ;
        end
    end

    rvc_parcel_select u_select (
        .wbuf            (pre_wbuf),
        .hbuf            (hbuf),
        .hbuf_valid      (pre_hbuf_valid),
        .off             (pre_pc[1]),
        .parcel          (sel_parcel),
        .is_compressed   (sel_compressed),
        .has_parcel      (sel_has_parcel),
        .needs_next_word (sel_needs_next)
    );

    // Second pass: a 32-bit instruction starting in the upper half parks its low half and refetches.
    always_comb begin
        nxt_state      = pre_state;
        nxt_hbuf       = hbuf;
        nxt_hbuf_valid = pre_hbuf_valid;
        if (pre_state == ST_HAVE && sel_needs_next) begin
            nxt_state      = ST_REQ;
            nxt_hbuf       = pre_wbuf[31:16];
            nxt_hbuf_valid = 1'b1;
        end
        fetch_pc = nxt_hbuf_valid ? (pre_pc + 32'd2) : pre_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_REQ;
            pc                 <= RESET_PC;
            wbuf               <= '0;
            hbuf               <= '0;
            hbuf_valid         <= 1'b0;
            imem_req           <= 1'b0;
            imem_addr          <= RESET_PC & ~32'd3;
            inst_valid         <= 1'b0;
            inst_pc            <= RESET_PC;
            inst_data          <= '0;
            inst_is_compressed <= 1'b0;
        end else begin
            state      <= nxt_state;
            pc         <= pre_pc;
            wbuf       <= pre_wbuf;
            hbuf       <= nxt_hbuf;
            hbuf_valid <= nxt_hbuf_valid;
            imem_req   <= (nxt_state == ST_REQ);
            if (nxt_state == ST_REQ) imem_addr <= fetch_pc & ~32'd3;
            inst_valid <= (nxt_state == ST_HAVE) && sel_has_parcel;
            inst_pc    <= pre_pc;
            if (nxt_state == ST_HAVE) begin
                inst_data          <= sel_parcel;
                inst_is_compressed <= sel_compressed;
            end
        end
    end

endmodule
